mem_ctrl: RTL
=============

# mem_ctrl

Memory controller between the core and the single-port, byte-wide RAM/IO bus. It serves instruction-block fills for the instruction fetch stage, the requester on the `mc_en`/`mc_pc`/`mc_done`/`mc_data` handshake. It also serves byte, half and word loads and stores for the load/store buffer. One transaction is in flight at a time, and multi-byte accesses are serialized as little-endian byte beats.

## Interface
Parameters:
- `IF_BLK_BYTES`, default 4: bytes per instruction-cache block fill; `if_data` width is `8*IF_BLK_BYTES`.
- `IO_BASE`, default 32'h30000: addresses ≥ `IO_BASE` are IO space.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `rdy` in 1: global enable; low freezes all state.
- `rollback` in 1: ROB misprediction flush.
- `io_buffer_full` in 1: IO write sink cannot accept.
- `mem_din` in 8: RAM read byte, valid the cycle after its address.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM byte address.
- `mem_wr` out 1: write strobe.
- `if_en` in 1: fetch block request; level, held until `if_done`.
- `if_pc` in 32: block-aligned fetch address.
- `if_done` out 1: one-cycle pulse when `if_data` is valid.
- `if_data` out `8*IF_BLK_BYTES`: fetched block, byte 0 in bits [7:0].
- `lsb_en` in 1: load/store request; level, held until `lsb_done`.
- `lsb_wr` in 1: 1 = store.
- `lsb_addr` in 32: access address.
- `lsb_len` in 2: access size; 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = reserved, treated as 4.
- `lsb_w_data` in 32: store data, low bytes used.
- `lsb_done` out 1: one-cycle completion pulse.
- `lsb_r_data` out 32: load data, zero-extended.

## Operation
- FSM states: `IDLE`, `IF_RD`, `LS_RD`, `LS_WR`, `DONE`.
- `IDLE`:
  - If `lsb_en`, go to `LS_WR` or `LS_RD` according to `lsb_wr`.
  - Else if `if_en`, go to `IF_RD`.
  - LSB has fixed priority over fetch.
  - Address, length and write data are latched on the accepting edge.
- Reads (`IF_RD`/`LS_RD`):
  - Issue counter `k` drives `mem_a = base + k`, k = 0..n-1, one byte per cycle.
  - `mem_din` is captured one cycle after each issue into byte lane `k-1`.
  - After the last capture, raise `done` and go to `DONE`.
- Writes (`LS_WR`): each cycle drives `mem_wr = 1`, `mem_a = base + k`, `mem_dout = byte k`.
- `DONE`: `done` is high; requests are not sampled. Unconditional transition to `IDLE`. This one-cycle gap keeps a requester's stale `en` from being re-accepted.
- Rollback:
  - In `LS_RD` or `IDLE`: abort the pending LSB read and return to `IDLE`. No `lsb_done`; `mem_a`/`mem_wr` are cleared.
  - `IF_RD` is not aborted; it completes and pulses `if_done`, because the fetch stage waits for it.
  - `LS_WR` is not aborted, since stores are committed.
- Address arithmetic is 32-bit wrap-around. Fetch-block bytes never cross the block.

## Timing
- Reset values:
  - `mem_a` = 0, `mem_dout` = 0, `mem_wr` = 0.
  - `if_done` = 0, `lsb_done` = 0.
  - `if_data` = 0, `lsb_r_data` = 0.
  - State = `IDLE`.
- `rst` mid-transaction drops the transaction immediately; `mem_wr` is 0 the next cycle.
- Read of n bytes: accepting edge E0 issues byte 0. `done` is high in the cycle after edge E(n+1), i.e. n+2 cycles after the request is first sampled in `IDLE`.
- Write of n bytes: bytes are on the bus in cycles after E0..E(n-1); `done` is high in the cycle after E(n), with `mem_wr` = 0 in that cycle.
- `rdy` low: state, counters and outputs hold; `mem_wr` is forced 0 combinationally.
- Simultaneous `if_en` and `lsb_en` in `IDLE`: LSB wins. Fetch is served after the `DONE` cycle if still requested.
- Data outputs hold their last value until the next completion.

## Configuration
- Macro: `MEM_CTRL_IO_GUARD_EN`.
- Defined:
  - A store with `lsb_addr ≥ IO_BASE` waits in `IDLE` (not accepted) while `io_buffer_full` is high.
  - Each IO write beat also stalls while `io_buffer_full` is high: `mem_wr` = 0, `k` holds.
- Undefined: `io_buffer_full` is ignored; all stores proceed at one byte per cycle.

## Structure
- Add to the shared `setsize.v` package:
  - `MC_LEN_B`, `MC_LEN_H`, `MC_LEN_W` encodings.
  - `IO_BASE` default.
  - `IF_DATA_WID`, consistent with `IF_BLK_BYTES`.
  - The state encodings.
- No sub-module; byte-lane assembly and serialization fit in the single module.

## Test plan
- Fetch only: `if_en`, `if_pc` = 0x100, RAM[0x100..0x103] = 13 05 A0 00.
  - `mem_a` sequence is 0x100..0x103.
  - `if_done` is a single pulse with `if_data` = 0x00A00513.
  - No re-accept in the following cycle.
- Word store then load at 0x2000 of 0xDEADBEEF.
  - Write bytes appear as EF, BE, AD, DE.
  - The load returns `lsb_r_data` = 0xDEADBEEF.
- Byte load at 0x2003 after the store above: `lsb_r_data` = 0x000000DE, with exactly one bus beat.
- `if_en` and `lsb_en` raised in the same cycle:
  - The LSB transaction completes first.
  - Then the fetch completes.
  - `if_done` and `lsb_done` are never high together.
- `rollback` during a 4-byte `LS_RD` after 2 beats:
  - No `lsb_done`.
  - Back in `IDLE` next cycle.
  - A concurrent `IF_RD` started later still completes.
- With `MEM_CTRL_IO_GUARD_EN` defined, a byte store to 0x30000 with `io_buffer_full` = 1 for 3 cycles:
  - `mem_wr` stays 0 during those cycles.
  - The write occurs on the first cycle after `io_buffer_full` falls.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: access-length encodings,
// default block/IO geometry and the FSM state encodings.
package mem_ctrl_pkg;

    // lsb_len encodings; the fourth code is reserved and behaves as a word
    localparam logic [1:0] MC_LEN_B = 2'b00;
    localparam logic [1:0] MC_LEN_H = 2'b01;
    localparam logic [1:0] MC_LEN_W = 2'b10;

    // Default geometry
    localparam int          IF_BLK_BYTES_DEF = 4;
    localparam int          IF_DATA_WID      = 8 * IF_BLK_BYTES_DEF;
    localparam logic [31:0] IO_BASE_DEF      = 32'h0003_0000;

    // Controller states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_IF_RD = 3'd1;
    localparam logic [2:0] ST_LS_RD = 3'd2;
    localparam logic [2:0] ST_LS_WR = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Number of byte beats for an lsb_len code
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            MC_LEN_B: return 3'd1;
            MC_LEN_H: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller between the core and the byte-wide RAM/IO bus.
// Serves instruction-block fills and LSB byte/half/word loads and stores,
// one transaction at a time, as little-endian byte beats.
// Optional feature macro: MEM_CTRL_IO_GUARD_EN -- when defined, stores to
// IO space (address >= IO_BASE) wait for io_buffer_full to be low, both
// before acceptance and on every beat.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          IF_BLK_BYTES = IF_BLK_BYTES_DEF,
    parameter logic [31:0] IO_BASE      = IO_BASE_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      rollback,
    input  logic                      io_buffer_full,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [31:0]               mem_a,
    output logic                      mem_wr,
    input  logic                      if_en,
    input  logic [31:0]               if_pc,
    output logic                      if_done,
    output logic [8*IF_BLK_BYTES-1:0] if_data,
    input  logic                      lsb_en,
    input  logic                      lsb_wr,
    input  logic [31:0]               lsb_addr,
    input  logic [1:0]                lsb_len,
    input  logic [31:0]               lsb_w_data,
    output logic                      lsb_done,
    output logic [31:0]               lsb_r_data
);

    // Capture buffer must hold either a fetch block or a 32-bit load
    localparam int BUF_BYTES = (IF_BLK_BYTES > 4) ? IF_BLK_BYTES : 4;
    // Counter runs one past the last capture (n+1)
    localparam int CNT_W = $clog2(BUF_BYTES + 2);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] BUF_LAST = CNT_W'(BUF_BYTES - 1);
    localparam logic [31:0]      BLK_MASK = ~(32'(IF_BLK_BYTES) - 32'd1);

    logic [2:0]             state;
    logic [CNT_W-1:0]       k;          // beats issued so far
    logic [CNT_W-1:0]       n;          // beats in the current transaction
    logic [31:0]            base;
    logic [31:0]            w_data;
    logic                   is_io;
    logic                   mem_wr_q;
    logic [8*BUF_BYTES-1:0] rd_buf;
    logic [8*BUF_BYTES-1:0] rd_merged;
    logic [CNT_W-1:0]       cap_idx;
    logic                   io_block_accept;
    logic                   io_stall_beat;

`ifdef MEM_CTRL_IO_GUARD_EN
    assign io_block_accept = lsb_wr && (lsb_addr >= IO_BASE) && io_buffer_full;
    assign io_stall_beat   = is_io && io_buffer_full;
`else
    logic unused_io;
    assign io_block_accept = 1'b0;
    assign io_stall_beat   = 1'b0;
    assign unused_io       = io_buffer_full ^ is_io;
`endif

    // The write strobe must drop immediately when the bus is frozen
    assign mem_wr = mem_wr_q & rdy;

    // Data returned by the RAM belongs to the beat issued two edges ago
    assign cap_idx = k - CNT_TWO;

    // Read buffer with the byte arriving this cycle merged into its lane
    always_comb begin
        // NOTE: assign a default before any conditional update so no latch is inferred.
        rd_merged = rd_buf;
        if (k >= CNT_TWO && cap_idx <= BUF_LAST) begin
            rd_merged[8*cap_idx +: 8] = mem_din;
        end
    end

    // Transaction FSM, bus drive, byte capture and completion outputs
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values.
        if (rst) begin
            state      <= ST_IDLE;
            k          <= '0;
            n          <= '0;
            base       <= '0;
            w_data     <= '0;
            is_io      <= 1'b0;
            rd_buf     <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr_q   <= 1'b0;
            if_done    <= 1'b0;
            lsb_done   <= 1'b0;
            if_data    <= '0;
            lsb_r_data <= '0;
        end else if (rdy) begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mem_wr_q <= 1'b0;
                    if (rollback) begin
                        mem_a <= '0;
                    end else if (lsb_en) begin
                        if (!io_block_accept) begin
                            base   <= lsb_addr;
                            n      <= CNT_W'(len_bytes(lsb_len));
                            w_data <= lsb_w_data;
                            is_io  <= lsb_addr >= IO_BASE;
                            rd_buf <= '0;
                            k      <= CNT_ONE;
                            mem_a  <= lsb_addr;
                            if (lsb_wr) begin
                                state    <= ST_LS_WR;
                                mem_wr_q <= 1'b1;
                                mem_dout <= lsb_w_data[7:0];
                            end else begin
                                state <= ST_LS_RD;
                            end
                        end
                    end else if (if_en) begin
                        base   <= if_pc & BLK_MASK;
                        n      <= CNT_W'(IF_BLK_BYTES);
                        is_io  <= 1'b0;
                        rd_buf <= '0;
                        k      <= CNT_ONE;
                        mem_a  <= if_pc & BLK_MASK;
                        state  <= ST_IF_RD;
                    end
                end

                ST_IF_RD, ST_LS_RD: begin
                    if (state == ST_LS_RD && rollback) begin
                        // Flushed load: drop it silently
                        state <= ST_IDLE;
                        mem_a <= '0;
                        k     <= '0;
                    end else begin
                        if (k < n) begin
                            mem_a <= base + 32'(k);
                        end
                        if (k >= CNT_TWO) begin
                            rd_buf <= rd_merged;
                        end
                        if (k == n + CNT_ONE) begin
                            state <= ST_DONE;
                            if (state == ST_IF_RD) begin
                                if_done <= 1'b1;
                                if_data <= rd_merged[8*IF_BLK_BYTES-1:0];
                            end else begin
                                lsb_done   <= 1'b1;
                                lsb_r_data <= rd_merged[31:0];
                            end
                        end
                        k <= k + CNT_ONE;
                    end
                end

                ST_LS_WR: begin
                    if (k == n) begin
                        mem_wr_q <= 1'b0;
                        lsb_done <= 1'b1;
                        state    <= ST_DONE;
                    end else if (io_stall_beat) begin
                        mem_wr_q <= 1'b0;
                    end else begin
                        mem_wr_q <= 1'b1;
                        mem_a    <= base + 32'(k);
                        mem_dout <= w_data[8*k[1:0] +: 8];
                        k        <= k + CNT_ONE;
                    end
                end

                // One dead cycle so a requester's stale enable is not re-accepted
                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
